// File: rtl/run_arbiter.sv
// rtl/run_arbiter.sv - four-way round-robin arbiter granting one timed run per winner
module run_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic [3:0]         req,
    input  logic [3:0]         mode,
    input  logic [4*LEN_W-1:0] len,
    input  logic               stop,
    output logic [3:0]         gnt,
    output logic [1:0]         state,
    output logic [3:0]         done,
    output logic               abort,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [LEN_W-1:0] cnt;
    logic             mlat;
    logic             owner_req;

    // Scan from the highest offset down so the nearest requester above ptr wins.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    assign owner_req = req[owner];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= ST_IDLE;
            gnt   <= 4'b0000;
            done  <= 4'b0000;
            abort <= 1'b0;
            ptr   <= 2'd0;
            owner <= 2'd0;
            cnt   <= '0;
            mlat  <= 1'b0;
        end else begin
            done  <= 4'b0000;
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 4'b0000) begin
                        state <= ST_RUN;
                        owner <= win;
                        gnt   <= 4'b0001 << win;
                        mlat  <= mode[win];
                        cnt   <= len[LEN_W*win +: LEN_W];
                    end
                end
                ST_RUN: begin
                    // Losing the request outranks normal completion.
                    if (!owner_req) begin
                        state <= ST_GAP;
                        gnt   <= 4'b0000;
                        abort <= 1'b1;
                    end else if (cnt == '0) begin
                        if (mlat) begin
                            state <= ST_GAP;
                            gnt   <= 4'b0000;
                            done  <= gnt;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!owner_req) begin
                        state <= ST_GAP;
                        gnt   <= 4'b0000;
                        abort <= 1'b1;
                    end else if (stop) begin
                        state <= ST_GAP;
                        gnt   <= 4'b0000;
                        done  <= gnt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= owner + 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_arbiter.sv
// tb/tb_run_arbiter.sv - randomized scoreboard bench for run_arbiter
module tb_run_arbiter;

    localparam int LEN_W = 4;

    logic               clk;
    logic               xrst;
    logic [3:0]         req;
    logic [3:0]         mode;
    logic [4*LEN_W-1:0] len;
    logic               stop;
    logic [3:0]         gnt;
    logic [1:0]         state;
    logic [3:0]         done;
    logic               abort;
    logic               busy;

    run_arbiter #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .xrst  (xrst),
        .req   (req),
        .mode  (mode),
        .len   (len),
        .stop  (stop),
        .gnt   (gnt),
        .state (state),
        .done  (done),
        .abort (abort),
        .busy  (busy)
    );

    typedef struct {
        int st;
        int g;
        int d;
        int a;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: phase 0 idle, 1 run, 2 wait, 3 gap.
    int m_phase  = 0;
    int m_owner  = 0;
    int m_left   = 0;
    int m_single = 0;
    int m_ptr    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input int r, input int m, input int l, input int s);
        exp_t e;
        int dn = 0;
        int ab = 0;
        case (m_phase)
            0: begin
                if (r != 0) begin
                    for (int k = 3; k >= 0; k--) begin
                        if (((r >> ((m_ptr + k) % 4)) & 1) == 1) m_owner = (m_ptr + k) % 4;
                    end
                    m_left   = ((l >> (4 * m_owner)) & 15) + 1;
                    m_single = (m >> m_owner) & 1;
                    m_phase  = 1;
                end
            end
            1: begin
                if (((r >> m_owner) & 1) == 0) begin
                    m_phase = 3;
                    ab = 1;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_single == 1) begin
                            m_phase = 3;
                            dn = 1;
                        end else begin
                            m_phase = 2;
                        end
                    end
                end
            end
            2: begin
                if (((r >> m_owner) & 1) == 0) begin
                    m_phase = 3;
                    ab = 1;
                end else if (s != 0) begin
                    m_phase = 3;
                    dn = 1;
                end
            end
            default: begin
                m_phase = 0;
                m_ptr   = (m_owner + 1) % 4;
            end
        endcase
        e.st = m_phase;
        e.g  = (m_phase == 1 || m_phase == 2) ? (1 << m_owner) : 0;
        e.d  = dn ? (1 << m_owner) : 0;
        e.a  = ab;
        return e;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic [3:0] m, input logic [15:0] l, input logic s);
        exp_t e;
        req  = r;
        mode = m;
        len  = l;
        stop = s;
        e = model_step(int'(r), int'(m), int'(l), int'(s));
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic reset_pulse();
        #5;
        xrst = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_abort", int'(abort), 0);
        #1;
        xrst = 1'b1;
        m_phase = 0;
        m_ptr   = 0;
        m_owner = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", int'(state), e.st);
                chk("gnt", int'(gnt), e.g);
                chk("done", int'(done), e.d);
                chk("abort", int'(abort), e.a);
                chk("busy", int'(busy), int'(e.st != 0));
            end
        end
    end

    initial begin
        logic [3:0] r;
        xrst = 1'b0;
        req  = 4'b0000;
        mode = 4'b0000;
        len  = 16'h0000;
        stop = 1'b0;
        #2;
        chk("init_gnt", int'(gnt), 0);
        chk("init_state", int'(state), 0);
        chk("init_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        xrst = 1'b1;

        // Round robin from a fresh pointer, one-cycle runs.
        repeat (15) cycle(4'b1111, 4'b1111, 16'h0000, 1'b0);
        repeat (3) cycle(4'b0000, 4'b1111, 16'h0000, 1'b0);

        // Single-shot run of four cycles.
        repeat (6) cycle(4'b0001, 4'b0001, 16'h0003, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0001, 16'h0003, 1'b0);

        // Hold in wait until stop, with stop noise on idle cycles first.
        cycle(4'b0010, 4'b0000, 16'h0000, 1'b1);
        repeat (11) cycle(4'b0010, 4'b0000, 16'h0000, 1'b0);
        cycle(4'b0010, 4'b0000, 16'h0000, 1'b1);
        repeat (2) cycle(4'b0000, 4'b0000, 16'h0000, 1'b0);

        // Abort in the second run cycle, next grant wraps from index 3.
        repeat (2) cycle(4'b0100, 4'b1111, 16'h0700, 1'b0);
        repeat (2) cycle(4'b0011, 4'b1111, 16'h0700, 1'b0);
        repeat (3) cycle(4'b0001, 4'b1111, 16'h0700, 1'b0);
        repeat (2) cycle(4'b0000, 4'b1111, 16'h0000, 1'b0);

        // Stop and request loss together in wait.
        repeat (3) cycle(4'b0010, 4'b0000, 16'h0000, 1'b0);
        cycle(4'b0000, 4'b0000, 16'h0000, 1'b1);
        repeat (2) cycle(4'b0000, 4'b0000, 16'h0000, 1'b0);

        // Reset during wait, then check the pointer restarted at 0.
        repeat (4) cycle(4'b1000, 4'b0000, 16'h0000, 1'b0);
        reset_pulse();
        repeat (4) cycle(4'b1111, 4'b1111, 16'h0000, 1'b0);
        repeat (2) cycle(4'b0000, 4'b1111, 16'h0000, 1'b0);

        // Full-length run.
        repeat (19) cycle(4'b0100, 4'b0100, 16'h0F00, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 16'h0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            if ((m_phase == 1 || m_phase == 2) && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
            cycle(r, 4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 5) == 0));
        end
        repeat (4) cycle(4'b0000, 4'b0000, 16'h0000, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
